// File: rtl/lru_age_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lru_age_tracker_pkg
// Description : Shared defaults, width derivations and FSM state encoding
//               for the LRU age tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package lru_age_tracker_pkg;

  localparam int DEF_WAYS = 4;
  localparam int DEF_SETS = 16;

  // Width of one age field; ages run 0..WAYS-1.
  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction

  // Width of the set index.
  function automatic int set_w(input int sets);
    return $clog2(sets);
  endfunction

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lru_age_update.sv
`default_nettype none
// ============================================================================
// Module      : lru_age_update
// Description : Combinational age update for one set. Picks the accessed way
//               (hit way, or the age-0 victim on a miss), promotes it to
//               WAYS-1 and decrements every way that was younger than it.
// Revision    : 1.0 - initial release
// ============================================================================
module lru_age_update
  import lru_age_tracker_pkg::*;
#(
  parameter  int WAYS  = DEF_WAYS,
  localparam int AGE_W = age_w(WAYS)
) (
  input  logic [WAYS*AGE_W-1:0] ages_in,
  input  logic                  hit,
  input  logic [AGE_W-1:0]      way,
  output logic [WAYS*AGE_W-1:0] ages_out,
  output logic [AGE_W-1:0]      acc_way
);

  logic [AGE_W-1:0] victim;
  logic [AGE_W-1:0] acc_age;

  // Victim is the unique way holding age 0.
  always_comb begin
    victim = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (ages_in[i*AGE_W +: AGE_W] == '0) victim = AGE_W'(i);
    end
  end

  // Accessed way and its current age.
  always_comb begin
    acc_way = hit ? way : victim;
    acc_age = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == acc_way) acc_age = ages_in[i*AGE_W +: AGE_W];
    end
  end

  // Promote the accessed way; shift down only those that were more recent.
  always_comb begin
    ages_out = ages_in;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == acc_way) begin
        ages_out[i*AGE_W +: AGE_W] = AGE_W'(WAYS - 1);
      end else if (ages_in[i*AGE_W +: AGE_W] > acc_age) begin
        ages_out[i*AGE_W +: AGE_W] = ages_in[i*AGE_W +: AGE_W] - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lru_age_tracker.sv
`default_nettype none
// ============================================================================
// Module      : lru_age_tracker
// Description : Per-set true-LRU age tracker. Two-stage pipeline: requests
//               are captured in stage 1, the set is read, updated and written
//               back in stage 2. An INIT sweep (after reset or inv_all)
//               writes age(way i) = i into every set, one set per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lru_age_tracker
  import lru_age_tracker_pkg::*;
#(
  parameter  int WAYS  = DEF_WAYS,
  parameter  int SETS  = DEF_SETS,
  localparam int AGE_W = age_w(WAYS),
  localparam int SET_W = set_w(SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SET_W-1:0]      req_set,
  input  logic                  req_hit,
  input  logic [AGE_W-1:0]      req_way,
  input  logic                  inv_all,
  output logic                  rsp_valid,
  output logic [AGE_W-1:0]      rsp_way,
  output logic                  rsp_miss,
  output logic                  init_done,
  input  logic [SET_W-1:0]      dbg_set,
  output logic [WAYS*AGE_W-1:0] dbg_ages
);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [SET_W-1:0]        sweep_cnt;
  logic [SET_W-1:0]        sweep_cnt_d;

  logic                    accept;
  logic                    s1_valid;
  logic [SET_W-1:0]        s1_set;
  logic                    s1_hit;
  logic [AGE_W-1:0]        s1_way;

  logic [WAYS*AGE_W-1:0]   ages [SETS];
  logic [WAYS*AGE_W-1:0]   init_vec;
  logic [WAYS*AGE_W-1:0]   cur_ages;
  logic [WAYS*AGE_W-1:0]   upd_ages;
  logic [AGE_W-1:0]        acc_way;

  // Reset pattern for one set: way i gets age i.
  for (genvar i = 0; i < WAYS; i++) begin : g_init
    assign init_vec[i*AGE_W +: AGE_W] = AGE_W'(i);
  end

  // FSM state and sweep counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      state_q   <= state_d;
      sweep_cnt <= sweep_cnt_d;
    end
  end

  // Next state: inv_all always restarts the sweep; INIT leaves after the last set.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt;
    if (inv_all) begin
      state_d     = ST_INIT;
      sweep_cnt_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_cnt_d = sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_SET) state_d = ST_RUN;
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign init_done = (state_q == ST_RUN);
  assign req_ready = (state_q == ST_RUN) && !inv_all;
  assign accept    = req_valid && req_ready;

  // Stage 1: capture the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_set   <= '0;
      s1_hit   <= 1'b0;
      s1_way   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_set <= req_set;
        s1_hit <= req_hit;
        s1_way <= req_way;
      end
    end
  end

  // Stage 2 reads the array directly, so a back-to-back access to the same
  // set sees the write from the previous cycle without any forwarding.
  assign cur_ages = ages[s1_set];
  assign dbg_ages = ages[dbg_set];

  lru_age_update #(
    .WAYS (WAYS)
  ) u_update (
    .ages_in  (cur_ages),
    .hit      (s1_hit),
    .way      (s1_way),
    .ages_out (upd_ages),
    .acc_way  (acc_way)
  );

  // Age array write: a stage-2 update completes first, the sweep follows.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      ages[s1_set] <= upd_ages;
    end else if (state_q == ST_INIT) begin
      ages[sweep_cnt] <= init_vec;
    end
  end

  assign rsp_valid = s1_valid;
  assign rsp_way   = s1_valid ? acc_way : '0;
  assign rsp_miss  = s1_valid && !s1_hit;

endmodule
`default_nettype wire
